// File: rtl/bus_tag_channel_pkg.sv
// rtl/bus_tag_channel_pkg.sv - shared encodings for the bus-and-tag channel controller
package bus_tag_channel_pkg;

   typedef enum logic [2:0] {
      STATE_IDLE,
      STATE_SELECT,
      STATE_ADDRESS,
      STATE_INITIAL_STATUS,
      STATE_DATA,
      STATE_ENDING
   } state_t;

   typedef enum logic [1:0] {
      DIR_NONE,
      DIR_READ,
      DIR_WRITE
   } dir_t;

   localparam logic [7:0] STATUS_ATTN = 8'h80;
   localparam logic [7:0] STATUS_SM   = 8'h40;
   localparam logic [7:0] STATUS_CUE  = 8'h20;
   localparam logic [7:0] STATUS_BUSY = 8'h10;
   localparam logic [7:0] STATUS_CE   = 8'h08;
   localparam logic [7:0] STATUS_DE   = 8'h04;
   localparam logic [7:0] STATUS_UC   = 8'h02;
   localparam logic [7:0] STATUS_UE   = 8'h01;

   // Read-backward (x..x1100) and sense (x..x0100) both move data inbound.
   function automatic dir_t command_dir(input logic [7:0] cmd);
      dir_t d;
      d = DIR_NONE;
      if (cmd[1:0] == 2'b01)
         d = DIR_WRITE;
      else if (cmd[1:0] == 2'b10 || cmd[3:0] == 4'b0100 || cmd[3:0] == 4'b1100)
         d = DIR_READ;
      return d;
   endfunction

endpackage

// File: rtl/bus_tag_channel.sv
// rtl/bus_tag_channel.sv - channel-side bus-and-tag selection, command, data and status sequencer
module bus_tag_channel #(
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic       clk,
   input  logic       reset,
   output logic [7:0] a_bus_out,
   input  logic [7:0] a_bus_in,
   output logic       a_operational_out,
   output logic       a_hold_out,
   output logic       a_select_out,
   output logic       a_address_out,
   output logic       a_command_out,
   output logic       a_service_out,
   output logic       a_suppress_out,
   input  logic       a_request_in,
   input  logic       a_select_in,
   input  logic       a_operational_in,
   input  logic       a_address_in,
   input  logic       a_status_in,
   input  logic       a_service_in,
   input  logic [7:0] addr,
   input  logic [7:0] command,
   input  logic       start,
   input  logic       stop,
   input  logic [7:0] data_send_tdata,
   input  logic       data_send_tvalid,
   output logic       data_send_tready,
   output logic [7:0] data_recv_tdata,
   output logic       data_recv_tvalid,
   input  logic       data_recv_tready,
   output logic [7:0] status,
   output logic       status_valid
);
   import bus_tag_channel_pkg::*;

   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) + 1 : 1;

   state_t        state;
   dir_t          dir;
   logic [7:0]    cmd_q;
   logic          stop_pend;
   logic          st_taken;
   logic [TW-1:0] timer;
   logic [4:0]    tags_q;
   logic [4:0]    tags_now;
   logic          timeout_hit;
   logic          unused_inputs;

   assign unused_inputs  = a_request_in;
   assign a_suppress_out = 1'b0;
   assign tags_now       = {a_select_in, a_operational_in, a_address_in, a_status_in, a_service_in};

   // The wait clock restarts on any inbound tag edge; waits on the host side never expire.
   assign timeout_hit = (TIMEOUT != 0) && (state != STATE_IDLE) &&
                        (32'(timer) == TIMEOUT - 1);

   always_ff @(posedge clk) begin
      if (reset) begin
         state             <= STATE_IDLE;
         dir               <= DIR_NONE;
         cmd_q             <= 8'h00;
         stop_pend         <= 1'b0;
         st_taken          <= 1'b0;
         timer             <= '0;
         tags_q            <= '0;
         a_bus_out         <= 8'h00;
         a_operational_out <= 1'b0;
         a_hold_out        <= 1'b0;
         a_select_out      <= 1'b0;
         a_address_out     <= 1'b0;
         a_command_out     <= 1'b0;
         a_service_out     <= 1'b0;
         data_send_tready  <= 1'b0;
         data_recv_tdata   <= 8'h00;
         data_recv_tvalid  <= 1'b0;
         status            <= 8'h00;
         status_valid      <= 1'b0;
      end else begin
         a_operational_out <= 1'b1;
         status_valid      <= 1'b0;
         tags_q            <= tags_now;

         if (state == STATE_IDLE || tags_now != tags_q || data_recv_tvalid || data_send_tready)
            timer <= '0;
         else
            timer <= timer + 1'b1;

         if (state != STATE_IDLE && stop)
            stop_pend <= 1'b1;

         if (timeout_hit) begin
            a_bus_out        <= 8'h00;
            a_hold_out       <= 1'b0;
            a_select_out     <= 1'b0;
            a_address_out    <= 1'b0;
            a_command_out    <= 1'b0;
            a_service_out    <= 1'b0;
            data_send_tready <= 1'b0;
            data_recv_tvalid <= 1'b0;
            state            <= STATE_IDLE;
         end else begin
            case (state)
               STATE_IDLE: begin
                  a_bus_out        <= 8'h00;
                  a_hold_out       <= 1'b0;
                  a_select_out     <= 1'b0;
                  a_address_out    <= 1'b0;
                  a_command_out    <= 1'b0;
                  a_service_out    <= 1'b0;
                  data_send_tready <= 1'b0;
                  data_recv_tvalid <= 1'b0;
                  stop_pend        <= 1'b0;
                  st_taken         <= 1'b0;
                  if (start) begin
                     cmd_q         <= command;
                     dir           <= command_dir(command);
                     a_bus_out     <= addr;
                     a_address_out <= 1'b1;
                     a_hold_out    <= 1'b1;
                     a_select_out  <= 1'b1;
                     state         <= STATE_SELECT;
                  end
               end

               STATE_SELECT: begin
                  if (a_select_in) begin
                     a_bus_out     <= 8'h00;
                     a_hold_out    <= 1'b0;
                     a_select_out  <= 1'b0;
                     a_address_out <= 1'b0;
                     state         <= STATE_IDLE;
                  end else if (a_status_in && !a_operational_in) begin
                     // Short busy: answered with a single service pulse, cleared again by IDLE.
                     status        <= a_bus_in;
                     a_service_out <= 1'b1;
                     a_bus_out     <= 8'h00;
                     a_hold_out    <= 1'b0;
                     a_select_out  <= 1'b0;
                     a_address_out <= 1'b0;
                     state         <= STATE_IDLE;
                  end else if (a_operational_in && a_address_in) begin
                     a_address_out <= 1'b0;
                     a_hold_out    <= 1'b0;
                     a_select_out  <= 1'b0;
                     a_bus_out     <= cmd_q;
                     a_command_out <= 1'b1;
                     state         <= STATE_ADDRESS;
                  end
               end

               STATE_ADDRESS: begin
                  if (!a_address_in) begin
                     a_command_out <= 1'b0;
                     a_bus_out     <= 8'h00;
                     state         <= STATE_INITIAL_STATUS;
                  end
               end

               STATE_INITIAL_STATUS: begin
                  if (!a_service_out) begin
                     if (a_status_in) begin
                        status        <= a_bus_in;
                        a_service_out <= 1'b1;
                        if (a_bus_in != 8'h00 || dir == DIR_NONE) begin
                           status_valid <= 1'b1;
                           st_taken     <= 1'b1;
                           state        <= STATE_ENDING;
                        end
                     end
                  end else if (!a_status_in) begin
                     a_service_out <= 1'b0;
                     state         <= STATE_DATA;
                  end
               end

               STATE_DATA: begin
                  if (a_status_in) begin
                     data_recv_tvalid <= 1'b0;
                     data_send_tready <= 1'b0;
                     a_service_out    <= 1'b0;
                     a_command_out    <= 1'b0;
                     st_taken         <= 1'b0;
                     state            <= STATE_ENDING;
                  end else if (a_service_out || a_command_out) begin
                     if (!a_service_in) begin
                        a_service_out <= 1'b0;
                        a_command_out <= 1'b0;
                     end
                  end else if (a_service_in) begin
                     // A completed handshake outranks a stop arriving in the same cycle.
                     if (dir == DIR_READ) begin
                        if (data_recv_tvalid && data_recv_tready) begin
                           data_recv_tvalid <= 1'b0;
                           a_service_out    <= 1'b1;
                        end else if (stop || stop_pend) begin
                           data_recv_tvalid <= 1'b0;
                           a_command_out    <= 1'b1;
                           stop_pend        <= 1'b0;
                        end else begin
                           data_recv_tvalid <= 1'b1;
                           data_recv_tdata  <= a_bus_in;
                        end
                     end else begin
                        if (data_send_tready && data_send_tvalid) begin
                           data_send_tready <= 1'b0;
                           a_bus_out        <= data_send_tdata;
                           a_service_out    <= 1'b1;
                        end else if (stop || stop_pend) begin
                           data_send_tready <= 1'b0;
                           a_command_out    <= 1'b1;
                           stop_pend        <= 1'b0;
                        end else begin
                           data_send_tready <= 1'b1;
                        end
                     end
                  end
               end

               STATE_ENDING: begin
                  if (a_status_in) begin
                     if (!st_taken) begin
                        status        <= a_bus_in;
                        status_valid  <= 1'b1;
                        a_service_out <= 1'b1;
                        st_taken      <= 1'b1;
                     end
                  end else begin
                     a_service_out <= 1'b0;
                     st_taken      <= 1'b0;
                     if (!a_operational_in) begin
                        a_bus_out        <= 8'h00;
                        a_hold_out       <= 1'b0;
                        a_select_out     <= 1'b0;
                        a_address_out    <= 1'b0;
                        a_command_out    <= 1'b0;
                        data_send_tready <= 1'b0;
                        data_recv_tvalid <= 1'b0;
                        state            <= STATE_IDLE;
                     end
                  end
               end

               default: state <= STATE_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bus_tag_channel.sv
// tb/tb_bus_tag_channel.sv - directed bench acting as host and control unit around bus_tag_channel
module tb_bus_tag_channel;
   import bus_tag_channel_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] a_bus_out;
   logic [7:0] a_bus_in;
   logic       a_operational_out, a_hold_out, a_select_out, a_address_out;
   logic       a_command_out, a_service_out, a_suppress_out;
   logic       a_request_in, a_select_in, a_operational_in, a_address_in, a_status_in, a_service_in;
   logic [7:0] addr, command;
   logic       start, stop;
   logic [7:0] data_send_tdata;
   logic       data_send_tvalid, data_send_tready;
   logic [7:0] data_recv_tdata;
   logic       data_recv_tvalid, data_recv_tready;
   logic [7:0] status;
   logic       status_valid;

   int         compared = 0;
   int         mismatched = 0;
   int         recv_hs = 0;
   int         send_hs = 0;
   logic [7:0] last_recv = 8'h00;

   always #5 clk = ~clk;

   bus_tag_channel #(.TIMEOUT(64)) dut (
      .clk(clk), .reset(reset),
      .a_bus_out(a_bus_out), .a_bus_in(a_bus_in),
      .a_operational_out(a_operational_out), .a_hold_out(a_hold_out),
      .a_select_out(a_select_out), .a_address_out(a_address_out),
      .a_command_out(a_command_out), .a_service_out(a_service_out),
      .a_suppress_out(a_suppress_out), .a_request_in(a_request_in),
      .a_select_in(a_select_in), .a_operational_in(a_operational_in),
      .a_address_in(a_address_in), .a_status_in(a_status_in), .a_service_in(a_service_in),
      .addr(addr), .command(command), .start(start), .stop(stop),
      .data_send_tdata(data_send_tdata), .data_send_tvalid(data_send_tvalid),
      .data_send_tready(data_send_tready), .data_recv_tdata(data_recv_tdata),
      .data_recv_tvalid(data_recv_tvalid), .data_recv_tready(data_recv_tready),
      .status(status), .status_valid(status_valid)
   );

   always @(posedge clk) begin
      if (data_recv_tvalid && data_recv_tready) begin
         recv_hs   <= recv_hs + 1;
         last_recv <= data_recv_tdata;
      end
      if (data_send_tvalid && data_send_tready)
         send_hs <= send_hs + 1;
   end

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic out_tag(input int id);
      case (id)
         0:       return a_address_out;
         1:       return a_command_out;
         2:       return a_service_out;
         3:       return a_select_out;
         default: return status_valid;
      endcase
   endfunction

   task automatic wait_tag(input string tag, input int id, input logic val, input int limit);
      int n = 0;
      while (out_tag(id) !== val && n < limit) begin
         tick();
         n++;
      end
      check(tag, 32'(out_tag(id)), 32'(val));
   endtask

   task automatic wait_idle(input string tag, input int limit);
      int n = 0;
      while (dut.state !== STATE_IDLE && n < limit) begin
         tick();
         n++;
      end
      check(tag, 32'(dut.state), 32'(STATE_IDLE));
   endtask

   task automatic start_op(input logic [7:0] a, input logic [7:0] c);
      addr = a;
      command = c;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic cu_select(input string tag, input logic [7:0] cu_addr, input logic [7:0] cmd);
      wait_tag({tag, ":select_out"}, 3, 1'b1, 10);
      check({tag, ":addr_on_bus"}, 32'(a_bus_out), 32'(cu_addr));
      a_operational_in = 1'b1;
      a_address_in = 1'b1;
      a_bus_in = cu_addr;
      wait_tag({tag, ":command_out"}, 1, 1'b1, 10);
      check({tag, ":cmd_on_bus"}, 32'(a_bus_out), 32'(cmd));
      a_address_in = 1'b0;
      a_bus_in = 8'h00;
      wait_tag({tag, ":command_drop"}, 1, 1'b0, 10);
   endtask

   task automatic cu_status(input string tag, input logic [7:0] st, input bit ends);
      a_status_in = 1'b1;
      a_bus_in = st;
      wait_tag({tag, ":status_service"}, 2, 1'b1, 10);
      check({tag, ":status"}, 32'(status), 32'(st));
      check({tag, ":status_valid"}, 32'(status_valid), 32'(ends));
      a_status_in = 1'b0;
      a_bus_in = 8'h00;
      if (ends) begin
         a_operational_in = 1'b0;
         wait_idle({tag, ":idle"}, 50);
      end else begin
         wait_tag({tag, ":status_service_drop"}, 2, 1'b0, 10);
      end
   endtask

   task automatic cu_byte(input string tag, input logic [7:0] d, output bit stopped);
      int n = 0;
      a_bus_in = d;
      a_service_in = 1'b1;
      while (!(a_service_out || a_command_out) && n < 20) begin
         tick();
         n++;
      end
      stopped = a_command_out;
      check({tag, ":byte_answer"}, 32'(a_service_out | a_command_out), 32'd1);
      a_service_in = 1'b0;
      a_bus_in = 8'h00;
      tick();
      check({tag, ":byte_release"}, 32'(a_service_out | a_command_out), 32'd0);
   endtask

   task automatic data_test(input string tag, input logic [7:0] cmd, input bit wr,
                            input int host_n, input int cu_lim, input int exp_xfer,
                            input int exp_left, input bit exp_stop);
      int  base_r = recv_hs;
      int  base_s = send_hs;
      int  xfer;
      bit  stopped = 1'b0;
      data_send_tvalid = wr;
      data_send_tdata = 8'h99;
      data_recv_tready = 1'b1;
      start_op(8'h1a, cmd);
      cu_select(tag, 8'h1a, cmd);
      cu_status(tag, 8'h00, 1'b0);
      for (int i = 0; i < cu_lim && !stopped; i++) begin
         cu_byte(tag, 8'h40 + 8'(i), stopped);
         if (!stopped) begin
            if (wr) check({tag, ":bus_out_data"}, 32'(a_bus_out), 32'h99);
            else    check({tag, ":recv_data"}, 32'(last_recv), 32'h40 + 32'(i));
         end
         if (i + 1 == host_n) begin
            stop = 1'b1;
            tick();
            stop = 1'b0;
         end
      end
      check({tag, ":stopped"}, 32'(stopped), 32'(exp_stop));
      a_status_in = 1'b1;
      a_bus_in = STATUS_CE | STATUS_DE;
      wait_tag({tag, ":end_service"}, 2, 1'b1, 10);
      check({tag, ":end_valid"}, 32'(status_valid), 32'd1);
      check({tag, ":end_status"}, 32'(status), 32'h0c);
      a_status_in = 1'b0;
      a_operational_in = 1'b0;
      a_bus_in = 8'h00;
      wait_idle({tag, ":idle"}, 10);
      xfer = wr ? (send_hs - base_s) : (recv_hs - base_r);
      check({tag, ":handshakes"}, 32'(xfer), 32'(exp_xfer));
      check({tag, ":host_left"}, 32'(host_n - xfer), 32'(exp_left));
      data_send_tvalid = 1'b0;
   endtask

   initial begin
      int base;
      int n;
      reset = 1'b1;
      a_bus_in = 8'h00;
      a_request_in = 1'b0; a_select_in = 1'b0; a_operational_in = 1'b0;
      a_address_in = 1'b0; a_status_in = 1'b0; a_service_in = 1'b0;
      addr = 8'h00; command = 8'h00; start = 1'b0; stop = 1'b0;
      data_send_tdata = 8'h00; data_send_tvalid = 1'b0; data_recv_tready = 1'b0;
      tick(3);
      check("reset_buses", {8'h00, a_bus_out, data_recv_tdata, status}, 32'h0);
      check("reset_tags", 32'({a_operational_out, a_hold_out, a_select_out, a_address_out,
                               a_command_out, a_service_out, a_suppress_out,
                               data_send_tready, data_recv_tvalid, status_valid}), 32'h0);
      reset = 1'b0;
      tick();
      check("operational_after_reset", 32'(a_operational_out), 32'd1);
      check("idle_after_reset", 32'(dut.state), 32'(STATE_IDLE));

      // No CU at 0x10: the CU at 0x1a passes select_out back as select_in.
      base = recv_hs + send_hs;
      start_op(8'h10, 8'h02);
      wait_tag("nocu:select_out", 3, 1'b1, 5);
      check("nocu:addr_on_bus", 32'(a_bus_out), 32'h10);
      a_select_in = 1'b1;
      wait_tag("nocu:select_drop", 3, 1'b0, 20);
      a_select_in = 1'b0;
      wait_idle("nocu:idle", 20);
      check("nocu:no_data", 32'(recv_hs + send_hs - base), 32'd0);

      // Busy CU answers the read with initial status 0x10.
      base = recv_hs + send_hs;
      start_op(8'h1a, 8'h02);
      cu_select("busy", 8'h1a, 8'h02);
      cu_status("busy", STATUS_BUSY, 1'b1);
      check("busy:no_data", 32'(recv_hs + send_hs - base), 32'd0);

      data_test("rd6_16",  8'h02, 1'b0, 6, 16, 6, 0, 1'b1);
      data_test("rd16_6",  8'h02, 1'b0, 16, 6, 6, 10, 1'b0);
      data_test("wr6_16",  8'h01, 1'b1, 6, 16, 6, 0, 1'b1);
      data_test("wr16_6",  8'h01, 1'b1, 16, 6, 6, 10, 1'b0);

      base = recv_hs + send_hs;
      start_op(8'h1a, 8'h03);
      cu_select("nop", 8'h1a, 8'h03);
      cu_status("nop", STATUS_CE | STATUS_DE, 1'b1);
      start_op(8'h1a, 8'hff);
      cu_select("inval", 8'h1a, 8'hff);
      cu_status("inval", STATUS_UC, 1'b1);
      check("nop_inval:no_data", 32'(recv_hs + send_hs - base), 32'd0);

      // Reset in the middle of a read byte that the host has not accepted.
      data_recv_tready = 1'b0;
      start_op(8'h1a, 8'h02);
      cu_select("rst", 8'h1a, 8'h02);
      cu_status("rst", 8'h00, 1'b0);
      a_bus_in = 8'h5a;
      a_service_in = 1'b1;
      tick(2);
      check("rst:tvalid_before", 32'(data_recv_tvalid), 32'd1);
      reset = 1'b1;
      tick();
      check("rst:buses", {8'h00, a_bus_out, data_recv_tdata, status}, 32'h0);
      check("rst:tags", 32'({a_operational_out, a_hold_out, a_select_out, a_address_out,
                             a_command_out, a_service_out, a_suppress_out,
                             data_send_tready, data_recv_tvalid, status_valid}), 32'h0);
      check("rst:idle", 32'(dut.state), 32'(STATE_IDLE));
      a_service_in = 1'b0; a_operational_in = 1'b0; a_bus_in = 8'h00;
      reset = 1'b0;
      tick();

      // Silent CU: selection is abandoned after TIMEOUT=64 cycles.
      start_op(8'h33, 8'h01);
      n = 0;
      while (a_select_out && n < 200) begin
         tick();
         n++;
      end
      check("timeout:select_drop", 32'(a_select_out), 32'd0);
      check("timeout:cycles", 32'(n), 32'd64);
      check("timeout:idle", 32'(dut.state), 32'(STATE_IDLE));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired before the directed sequence completed");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/bus_tag_channel.md
Name: bus_tag_channel

Overview:
Channel-side controller for an IBM System/360-style bus-and-tag I/O interface (interface "A"). It performs initial selection of one control unit (CU) by address, issues a single command byte, and moves data bytes between the CU and AXI-Stream-like send/receive ports. It then accepts ending status and returns to idle. It sits between a host sequencer, which supplies addr/command/start/stop and byte streams, and the cabled bus-and-tag chain of CUs.

Parameters:
TIMEOUT, 1024, cycles to wait for any expected inbound tag before abandoning the operation (drop all outbound tags, go IDLE); 0 disables the timeout.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
a_bus_out  out  8  bus out: address, command or write data
a_bus_in  in  8  bus in: CU address, status or read data
a_operational_out  out  1  high whenever reset is low
a_hold_out / a_select_out  out  1  selection tags
a_address_out / a_command_out / a_service_out  out  1  outbound tags
a_suppress_out  out  1  tied 0
a_request_in / a_select_in / a_operational_in / a_address_in / a_status_in / a_service_in  in  1  inbound tags (request_in ignored)
addr  in  8  target CU address, sampled at start
command  in  8  command byte, sampled at start
start  in  1  1-cycle pulse; honoured only in IDLE
stop  in  1  1-cycle pulse; ends the data transfer at the next service_in
data_send_tdata  in  8  write data
data_send_tvalid  in  1  write data valid
data_send_tready  out  1  channel requests a write byte
data_recv_tdata  out  8  read data
data_recv_tvalid  out  1  read byte available
data_recv_tready  in  1  host accepts read byte
status  out  8  last status byte accepted from the CU
status_valid  out  1  1-cycle pulse when an ending status is accepted

Behaviour:
- All outputs are registered. During reset every output is 0, including operational_out, and the state machine enters IDLE. Reset asserted mid-operation aborts immediately with no handshake.
- Direction is decoded from the sampled command:
  - write when command[1:0]=01;
  - read when command[1:0]=10, or command[3:0]=0100 or 1100;
  - otherwise no data phase (control, NOP, invalid).
- State IDLE: start latches addr and command, then goes to SELECT.
- State SELECT:
  - bus_out=addr, address_out=1, hold_out=select_out=1.
  - select_in=1 (no CU claimed the address): drop all tags and go IDLE.
  - status_in=1 with operational_in=0 (short busy): pulse service_out, latch status, go IDLE.
  - operational_in and address_in both 1: go to ADDRESS.
- State ADDRESS: drop address_out, drop hold_out/select_out, put the command on bus_out, raise command_out. When address_in falls, drop command_out and go to INITIAL_STATUS.
- State INITIAL_STATUS:
  - On status_in, latch bus_in into status and raise service_out.
  - Status byte 0x00 with a read or write command: hold service_out until status_in falls, then go DATA.
  - Any nonzero status (busy 0x10, unit check 0x02, channel end/device end 0x0C, ...) or a no-data command: ENDING.
- State DATA: on service_in:
  - Read: data_recv_tdata=bus_in, data_recv_tvalid=1 until the handshake (tvalid and tready both high at a clock edge). Then raise service_out.
  - Write: data_send_tready=1 until the handshake. Then drive bus_out=tdata and raise service_out.
  - tready/tvalid deassert on the cycle after the handshake and stay low until the next service_in.
  - In both directions service_out drops after service_in falls.
  - A stop pulse, pending or arriving while a byte is awaited: deassert tvalid/tready (the byte is not transferred) and answer that service_in with command_out instead of service_out. command_out drops after service_in falls.
  - status_in in DATA: go ENDING.
- State ENDING: on status_in, latch status, pulse status_valid, raise service_out. When status_in and operational_in are both low, drop all tags and go IDLE.
- Each inbound handshake is bounded by TIMEOUT.
- Simultaneous start and stop in IDLE: start wins and stop is ignored.

Decomposition:
- Shared package holds:
  - state encodings: STATE_IDLE, SELECT, ADDRESS, INITIAL_STATUS, DATA, ENDING;
  - status bit constants: ATTN 0x80, SM 0x40, CUE 0x20, BUSY 0x10, CE 0x08, DE 0x04, UC 0x02, UE 0x01;
  - command direction decode function.
- No sub-module is required. mock_cu (params ADDRESS, ENABLE_SHORT_BUSY; inputs mock_busy, mock_limit) is a separate verification model: a CU that forwards select_out to select_in on address mismatch.

Test Plan:
- Address 0x10, no CU at that address (CU at 0x1a, select looped back) -> select_in returns; IDLE within 20 cycles; no data handshake.
- CU busy, READ 0x02 to 0x1a -> initial status 0x10 accepted with service_out; IDLE within 50 cycles; no data.
- READ, host count 6, CU limit 16 -> 6 recv handshakes; 7th service_in stopped with command_out; IDLE; count 0.
- READ, count 16, CU limit 6 -> 6 bytes then ending status; IDLE; count 10. Same two cases for WRITE 0x01 (bus_out carries 0x99) -> counts 0 and 10.
- NOP 0x03 and invalid command 0xff -> initial status is nonzero (CE|DE or UC), no data phase, IDLE within 50 cycles.
- Reset asserted during DATA -> all outputs 0 on the next cycle, state IDLE.
